// File: rtl/core_pack.sv
// rtl/core_pack.sv - shared core types for the memory data path
package CorePack;

    typedef logic [63:0] addr_t;
    typedef logic [63:0] data_t;
    typedef logic [7:0]  mask_t;

    typedef enum logic [3:0] {
        MEM_NO = 4'd0,
        MEM_B  = 4'd1,
        MEM_H  = 4'd2,
        MEM_W  = 4'd3,
        MEM_D  = 4'd4,
        MEM_UB = 4'd5,
        MEM_UH = 4'd6,
        MEM_UW = 4'd7
    } mem_op_enum;

    typedef struct packed {
        addr_t waddr;
        data_t wdata;
        mask_t wmask;
    } store_entry_t;

endpackage

// File: rtl/store_pack.sv
// rtl/store_pack.sv - combinational store lane packer and alignment check
//
// Ports:
//   st_op, st_addr, st_data : incoming store request fields
//   waddr                   : doubleword address (low three bits cleared)
//   wdata                   : value moved into its byte lanes, other bytes zero
//   wmask                   : byte enables for the written lanes
//   misaligned              : store of a known width at an address it cannot take
//   enq                     : store should be written to the queue
module store_pack
    import CorePack::*;
(
    input  mem_op_enum st_op,
    input  addr_t      st_addr,
    input  data_t      st_data,
    output addr_t      waddr,
    output data_t      wdata,
    output mask_t      wmask,
    output logic       misaligned,
    output logic       enq
);

    logic [7:0]  byte_mask;
    logic [63:0] width_mask;
    logic        aligned;
    logic        valid_op;
    logic [2:0]  off;

    always_comb begin
        byte_mask  = 8'h00;
        width_mask = 64'h0;
        aligned    = 1'b1;
        valid_op   = 1'b1;
        case (st_op)
            MEM_B, MEM_UB: begin
                byte_mask  = 8'h01;
                width_mask = 64'h0000_0000_0000_00FF;
            end
            MEM_H, MEM_UH: begin
                byte_mask  = 8'h03;
                width_mask = 64'h0000_0000_0000_FFFF;
                aligned    = (st_addr[0] == 1'b0);
            end
            MEM_W, MEM_UW: begin
                byte_mask  = 8'h0F;
                width_mask = 64'h0000_0000_FFFF_FFFF;
                aligned    = (st_addr[1:0] == 2'b00);
            end
            MEM_D: begin
                byte_mask  = 8'hFF;
                width_mask = 64'hFFFF_FFFF_FFFF_FFFF;
                aligned    = (st_addr[2:0] == 3'b000);
            end
            default: begin
                valid_op = 1'b0;
            end
        endcase
    end

    assign off        = st_addr[2:0];
    assign waddr      = {st_addr[63:3], 3'b000};
    assign wdata      = (st_data & width_mask) << {off, 3'b000};
    assign wmask      = byte_mask << off;
    assign misaligned = valid_op && !aligned;
    assign enq        = valid_op && aligned;

endmodule

// File: rtl/store_unit.sv
// rtl/store_unit.sv - store packing, in-order store queue and memory write drain
//
// Ports:
//   clk, rstn          : clock, synchronous active-low reset
//   st_valid/st_ready  : store request handshake from the MEM stage
//   st_op/addr/data    : store width, byte address, LSB-justified value
//   dmem_wen/wready    : write handshake toward data memory (head of queue)
//   dmem_waddr/wdata/wmask : head entry, zero while the queue is empty
//   misalign           : one-cycle pulse after a dropped misaligned store
//   ld_check_addr      : load address to compare against pending stores
//   ld_conflict        : a pending store hits the load's doubleword
//   empty              : queue holds no entries
module store_unit
    import CorePack::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       st_valid,
    output logic       st_ready,
    input  mem_op_enum st_op,
    input  addr_t      st_addr,
    input  data_t      st_data,
    output logic       dmem_wen,
    input  logic       dmem_wready,
    output addr_t      dmem_waddr,
    output data_t      dmem_wdata,
    output mask_t      dmem_wmask,
    output logic       misalign,
    input  addr_t      ld_check_addr,
    output logic       ld_conflict,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    store_entry_t       entries [DEPTH];
    logic [DEPTH-1:0]   slot_valid;
    logic [AW:0]        wr_ptr;
    logic [AW:0]        rd_ptr;
    logic [AW-1:0]      wr_idx;
    logic [AW-1:0]      rd_idx;
    logic               full;
    logic               accept;
    logic               push;
    logic               pop;
    logic               misalign_q;

    addr_t              pk_waddr;
    data_t              pk_wdata;
    mask_t              pk_wmask;
    logic               pk_misaligned;
    logic               pk_enq;
    store_entry_t       head;

    store_pack u_pack (
        .st_op      (st_op),
        .st_addr    (st_addr),
        .st_data    (st_data),
        .waddr      (pk_waddr),
        .wdata      (pk_wdata),
        .wmask      (pk_wmask),
        .misaligned (pk_misaligned),
        .enq        (pk_enq)
    );

    assign wr_idx = wr_ptr[AW-1:0];
    assign rd_idx = rd_ptr[AW-1:0];

    // Extra wrap bit distinguishes full from empty when indices coincide.
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);
    assign empty = (wr_ptr == rd_ptr);

    // Ready ignores a same-cycle pop so st_ready never depends on dmem_wready.
    assign st_ready = !full;
    assign accept   = st_valid && st_ready;
    assign push     = accept && pk_enq;
    assign dmem_wen = !empty;
    assign pop      = dmem_wen && dmem_wready;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            slot_valid <= '0;
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= accept && pk_misaligned;
            if (push) begin
                slot_valid[wr_idx] <= 1'b1;
                wr_ptr             <= wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (pop) begin
                slot_valid[rd_idx] <= 1'b0;
                rd_ptr             <= rd_ptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Payload storage needs no reset: slot_valid and the pointers gate all use.
    always_ff @(posedge clk) begin
        if (push) begin
            entries[wr_idx] <= '{waddr: pk_waddr, wdata: pk_wdata, wmask: pk_wmask};
        end
    end

    assign head       = entries[rd_idx];
    assign dmem_waddr = empty ? '0 : head.waddr;
    assign dmem_wdata = empty ? '0 : head.wdata;
    assign dmem_wmask = empty ? '0 : head.wmask;
    assign misalign   = misalign_q;

    // Doubleword match only; the byte offset of the load is irrelevant here.
    logic unused_ld_low;
    assign unused_ld_low = ^ld_check_addr[2:0];

    always_comb begin
        ld_conflict = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_valid[i] && (entries[i].waddr[63:3] == ld_check_addr[63:3])) begin
                ld_conflict = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_store_unit.sv
// tb/tb_store_unit.sv - directed self-checking bench for store_unit
module tb_store_unit;
    import CorePack::*;

    logic       clk;
    logic       rstn;
    logic       st_valid;
    logic       st_ready;
    mem_op_enum st_op;
    addr_t      st_addr;
    data_t      st_data;
    logic       dmem_wen;
    logic       dmem_wready;
    addr_t      dmem_waddr;
    data_t      dmem_wdata;
    mask_t      dmem_wmask;
    logic       misalign;
    addr_t      ld_check_addr;
    logic       ld_conflict;
    logic       empty;

    int n_cmp;
    int n_bad;

    store_unit #(.DEPTH(2)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .st_valid      (st_valid),
        .st_ready      (st_ready),
        .st_op         (st_op),
        .st_addr       (st_addr),
        .st_data       (st_data),
        .dmem_wen      (dmem_wen),
        .dmem_wready   (dmem_wready),
        .dmem_waddr    (dmem_waddr),
        .dmem_wdata    (dmem_wdata),
        .dmem_wmask    (dmem_wmask),
        .misalign      (misalign),
        .ld_check_addr (ld_check_addr),
        .ld_conflict   (ld_conflict),
        .empty         (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_head(input string tag, input logic [63:0] a,
                              input logic [63:0] d, input logic [7:0] m);
        check({tag, " wen"},   64'(dmem_wen), 64'd1);
        check({tag, " waddr"}, dmem_waddr, a);
        check({tag, " wdata"}, dmem_wdata, d);
        check({tag, " wmask"}, 64'(dmem_wmask), 64'(m));
    endtask

    task automatic drive(input mem_op_enum op, input logic [63:0] a, input logic [63:0] d);
        st_valid = 1'b1;
        st_op    = op;
        st_addr  = a;
        st_data  = d;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rstn          = 1'b0;
        st_valid      = 1'b0;
        st_op         = MEM_NO;
        st_addr       = '0;
        st_data       = '0;
        dmem_wready   = 1'b1;
        ld_check_addr = '0;
        @(negedge clk);
        tick();
        rstn = 1'b1;
        tick();

        check("rst st_ready",    64'(st_ready),    64'd1);
        check("rst wen",         64'(dmem_wen),    64'd0);
        check("rst waddr",       dmem_waddr,       64'd0);
        check("rst wdata",       dmem_wdata,       64'd0);
        check("rst wmask",       64'(dmem_wmask),  64'd0);
        check("rst misalign",    64'(misalign),    64'd0);
        check("rst ld_conflict", 64'(ld_conflict), 64'd0);
        check("rst empty",       64'(empty),       64'd1);

        // Byte store into lane 3
        drive(MEM_B, 64'h1003, 64'hFFFF_FFFF_FFFF_FFAB);
        tick();
        st_valid = 1'b0;
        check_head("sb", 64'h1000, 64'h0000_0000_AB00_0000, 8'h08);
        tick();
        check("sb drained", 64'(empty), 64'd1);

        // Back-to-back H, W, D with wready high: one per cycle, in order
        drive(MEM_H, 64'h2006, 64'h1234);
        tick();
        check_head("sh", 64'h2000, 64'h1234_0000_0000_0000, 8'hC0);
        check("sh st_ready", 64'(st_ready), 64'd1);
        drive(MEM_W, 64'h3004, 64'hDEAD_BEEF);
        tick();
        check_head("sw", 64'h3000, 64'hDEAD_BEEF_0000_0000, 8'hF0);
        drive(MEM_D, 64'h4000, 64'h0123_4567_89AB_CDEF);
        tick();
        st_valid = 1'b0;
        check_head("sd", 64'h4000, 64'h0123_4567_89AB_CDEF, 8'hFF);
        tick();
        check("hsd drained", 64'(empty), 64'd1);

        // Misaligned word: dropped with a single-cycle pulse
        drive(MEM_W, 64'h1002, 64'h5555_AAAA);
        tick();
        st_valid = 1'b0;
        check("mis pulse", 64'(misalign), 64'd1);
        check("mis wen",   64'(dmem_wen), 64'd0);
        check("mis empty", 64'(empty),    64'd1);
        tick();
        check("mis clear", 64'(misalign), 64'd0);

        // MEM_NO: accepted, nothing queued, no pulse
        drive(MEM_NO, 64'h1001, 64'h77);
        tick();
        st_valid = 1'b0;
        check("no_op empty",    64'(empty),    64'd1);
        check("no_op misalign", 64'(misalign), 64'd0);

        // Backpressure: fill with wready low, then drain one per cycle
        dmem_wready = 1'b0;
        drive(MEM_B, 64'h6000, 64'h11);
        tick();
        drive(MEM_UB, 64'h6001, 64'h22);
        tick();
        drive(MEM_B, 64'h6002, 64'h33);
        check("bp full st_ready", 64'(st_ready), 64'd0);
        check_head("bp head0", 64'h6000, 64'h11, 8'h01);
        tick();
        check_head("bp head0 stable", 64'h6000, 64'h11, 8'h01);
        check("bp still full", 64'(st_ready), 64'd0);
        dmem_wready = 1'b1;
        tick();
        check_head("bp head1", 64'h6000, 64'h2200, 8'h02);
        check("bp st_ready after pop", 64'(st_ready), 64'd1);
        tick();
        st_valid = 1'b0;
        check_head("bp head2", 64'h6000, 64'h33_0000, 8'h04);
        tick();
        check("bp drained", 64'(empty), 64'd1);

        // Load conflict against a pending doubleword store
        dmem_wready = 1'b0;
        drive(MEM_D, 64'h5008, 64'hCAFE_F00D_0000_0001);
        tick();
        st_valid = 1'b0;
        ld_check_addr = 64'h500C;
        #1;
        check("conflict hit", 64'(ld_conflict), 64'd1);
        ld_check_addr = 64'h5010;
        #1;
        check("conflict miss", 64'(ld_conflict), 64'd0);

        // Reset mid-drain discards queued entries
        drive(MEM_UH, 64'h7002, 64'hBEEF);
        tick();
        st_valid = 1'b0;
        check("pre-rst full", 64'(st_ready), 64'd0);
        dmem_wready = 1'b1;
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        check("post-rst wen",      64'(dmem_wen),   64'd0);
        check("post-rst empty",    64'(empty),      64'd1);
        check("post-rst st_ready", 64'(st_ready),   64'd1);
        check("post-rst wmask",    64'(dmem_wmask), 64'd0);
        ld_check_addr = 64'h5008;
        #1;
        check("post-rst conflict", 64'(ld_conflict), 64'd0);
        tick();
        check("post-rst wen later", 64'(dmem_wen), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
